pll_lock_reset_gen: RTL and testbench
=====================================

PLL_LOCK_RESET_GEN -- requirements
Module: pll_lock_reset_gen

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 27000: cycles synchronized lock must hold before core reset release (1 ms at 27 MHz).
REQ-002 Parameter RELEASE_GAP_CYCLES, default 64: cycles between core and peripheral reset release.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 270000: cycles waiting for lock before the PLL is reset (10 ms).
REQ-004 Parameter PLL_RST_CYCLES, default 27: width of the PLL reset pulse in cycles.
REQ-005 clkin  input  1  free-running 27 MHz crystal clock; the only clock; never the PLL output.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 locked  input  1  PLL lock, asynchronous to clkin.
REQ-008 clear_status  input  1  synchronous single-cycle pulse; clears loss_count and lock_lost.
REQ-009 pll_reset  output  1  active-high reset to the PLL RESET pin.
REQ-010 rst_core  output  1  active-high reset for core logic (clk72 domain; that domain synchronizes deassertion).
REQ-011 rst_periph  output  1  active-high reset for peripherals (SPI, serial, PWM).
REQ-012 ready  output  1  high only in RUN.
REQ-013 loss_count  output  8  lock-loss events since last clear, saturating at 255.
REQ-014 lock_lost  output  1  sticky lock-loss flag.
REQ-015 retry_count  output  4  PLL resets caused by timeout, saturating at 15.

Function
REQ-016 locked SHALL pass through a 2-flop synchronizer, both flops reset to 0; lock_s is the second flop; all decisions use lock_s only.
REQ-017 States SHALL be PLL_RST, WAIT_LOCK, STABLE, REL_CORE, RUN; one shared down/up counter sized to the largest parameter.
REQ-018 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-019 PLL_RST: pll_reset=1, rst_core=rst_periph=1; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK with counter cleared and pll_reset=0.
REQ-020 WAIT_LOCK: counter increments each cycle; lock_s=1 -> STABLE (counter cleared); counter reaching LOCK_TIMEOUT_CYCLES with lock_s=0 -> PLL_RST and retry_count+1 (saturating).
REQ-021 STABLE: lock_s=0 -> WAIT_LOCK, no loss counted; LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 -> REL_CORE, rst_core=0 from the first REL_CORE cycle.
REQ-022 REL_CORE: after RELEASE_GAP_CYCLES cycles -> RUN; rst_periph=0 and ready=1 from the first RUN cycle.
REQ-023 REL_CORE or RUN with lock_s=0: next cycle rst_core=rst_periph=1, ready=0, lock_lost=1, loss_count+1 (saturating), state -> WAIT_LOCK, counter cleared.
REQ-024 Lock glitch shorter than 2 clkin cycles MAY be filtered by the synchronizer; any glitch seen on lock_s SHALL be handled per REQ-021/023.
REQ-025 clear_status in the same cycle as a loss event: event wins; loss_count becomes 1, lock_lost stays 1.
REQ-026 clear_status SHALL NOT affect retry_count, state or resets.
REQ-027 Reset ordering invariant: rst_periph SHALL never be 0 while rst_core is 1; ready=1 iff rst_periph=0.

Reset
REQ-028 rst assertion SHALL immediately force state=PLL_RST, counter=0, pll_reset=1, rst_core=1, rst_periph=1, ready=0, loss_count=0, lock_lost=0, retry_count=0, synchronizer=0.
REQ-029 Reset-entry PLL_RST SHALL NOT increment retry_count; after rst deasserts, pll_reset stays high PLL_RST_CYCLES cycles.
REQ-030 rst asserted mid-sequence (any state) SHALL behave identically to power-up reset.

Verification (bench parameters: LOCK_STABLE=8, RELEASE_GAP=4, LOCK_TIMEOUT=32, PLL_RST=3)
REQ-031 Power-up: rst released, locked raised after pll_reset falls -> pll_reset high 3 cycles; rst_core falls 10 cycles after locked rises (2 sync + 8); rst_periph and ready follow 4 cycles later.
REQ-032 Timeout: locked held 0 -> pll_reset re-pulses 3 cycles every 35 cycles; retry_count 1,2,... saturating at 15 after 15 timeouts.
REQ-033 Lock loss in RUN: locked dropped -> both resets high 3 cycles later (2 sync + 1), ready=0, loss_count=1, lock_lost=1; relock repeats the REQ-031 timing.
REQ-034 Unstable lock: locked high 5 cycles then low during STABLE -> rst_core never falls, loss_count stays 0.
REQ-035 Status: 256 loss events -> loss_count=255; clear_status coincident with a loss -> loss_count=1; lone clear_status -> 0, lock_lost=0.
REQ-036 Mid-operation reset: rst pulsed in RUN with loss_count=3 -> all outputs to REQ-028 values within the rst assertion, counters zero.

Source files
------------

// File: rtl/pll_lock_reset_gen.sv
// rtl/pll_lock_reset_gen.sv - PLL lock supervision and ordered core/peripheral reset release
module pll_lock_reset_gen #(
    parameter int LOCK_STABLE_CYCLES  = 27000,
    parameter int RELEASE_GAP_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int PLL_RST_CYCLES      = 27
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    input  logic       clear_status,
    output logic       pll_reset,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int MAX_AB     = (LOCK_STABLE_CYCLES > RELEASE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_GAP_CYCLES;
    localparam int MAX_CD     = (LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ? LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // Terminal counter values. The WAIT_LOCK cycle that first sees lock_s=1
    // already counts as the first stable cycle, so STABLE itself needs one fewer.
    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_REL_CORE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync1_d;
    logic          lock_s_q, lock_s_d;
    logic          pll_reset_q, pll_reset_d;
    logic          rst_core_q, rst_core_d;
    logic          rst_periph_q, rst_periph_d;
    logic          ready_q, ready_d;
    logic [7:0]    loss_count_q, loss_count_d;
    logic          lock_lost_q, lock_lost_d;
    logic [3:0]    retry_count_q, retry_count_d;
    logic          loss_event;
    logic [7:0]    loss_base;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_comb begin
        sync1_d  = locked;
        lock_s_d = sync1_q;
    end

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pll_reset_d   = pll_reset_q;
        rst_core_d    = rst_core_q;
        rst_periph_d  = rst_periph_q;
        ready_d       = ready_q;
        loss_count_d  = loss_count_q;
        lock_lost_d   = lock_lost_q;
        retry_count_d = retry_count_q;
        loss_event    = 1'b0;
        loss_base     = clear_status ? 8'd0 : loss_count_q;

        if (clear_status) begin
            loss_count_d = 8'd0;
            lock_lost_d  = 1'b0;
        end

        case (state_q)
            ST_PLL_RST: begin
                pll_reset_d  = 1'b1;
                rst_core_d   = 1'b1;
                rst_periph_d = 1'b1;
                ready_d      = 1'b0;
                if (cnt_q == PLL_RST_LAST) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_PLL_RST;
                    cnt_d         = '0;
                    pll_reset_d   = 1'b1;
                    retry_count_d = (retry_count_q == 4'hF) ? 4'hF : retry_count_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d    = ST_REL_CORE;
                    cnt_d      = '0;
                    rst_core_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REL_CORE: begin
                if (!lock_s_q) begin
                    loss_event = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    rst_periph_d = 1'b0;
                    ready_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // A loss overrides a coincident clear: the count restarts at one
        if (loss_event) begin
            state_d      = ST_WAIT_LOCK;
            cnt_d        = '0;
            rst_core_d   = 1'b1;
            rst_periph_d = 1'b1;
            ready_d      = 1'b0;
            lock_lost_d  = 1'b1;
            loss_count_d = (loss_base == 8'hFF) ? 8'hFF : loss_base + 8'd1;
        end
    end

    // State, counter, synchronizer and output registers with asynchronous reset
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            pll_reset_q   <= 1'b1;
            rst_core_q    <= 1'b1;
            rst_periph_q  <= 1'b1;
            ready_q       <= 1'b0;
            loss_count_q  <= 8'd0;
            lock_lost_q   <= 1'b0;
            retry_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= sync1_d;
            lock_s_q      <= lock_s_d;
            pll_reset_q   <= pll_reset_d;
            rst_core_q    <= rst_core_d;
            rst_periph_q  <= rst_periph_d;
            ready_q       <= ready_d;
            loss_count_q  <= loss_count_d;
            lock_lost_q   <= lock_lost_d;
            retry_count_q <= retry_count_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign rst_core    = rst_core_q;
    assign rst_periph  = rst_periph_q;
    assign ready       = ready_q;
    assign loss_count  = loss_count_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_count_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// tb/tb_pll_lock_reset_gen.sv - scoreboard bench for pll_lock_reset_gen
module tb_pll_lock_reset_gen;

    logic       clkin;
    logic       rst;
    logic       locked;
    logic       clear_status;
    logic       pll_reset;
    logic       rst_core;
    logic       rst_periph;
    logic       ready;
    logic [7:0] loss_count;
    logic       lock_lost;
    logic [3:0] retry_count;

    pll_lock_reset_gen #(
        .LOCK_STABLE_CYCLES (8),
        .RELEASE_GAP_CYCLES (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .PLL_RST_CYCLES     (3)
    ) dut (
        .clkin       (clkin),
        .rst         (rst),
        .locked      (locked),
        .clear_status(clear_status),
        .pll_reset   (pll_reset),
        .rst_core    (rst_core),
        .rst_periph  (rst_periph),
        .ready       (ready),
        .loss_count  (loss_count),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    typedef struct {
        int          cyc;
        logic [16:0] vec;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          end_req = 0;
    logic [16:0] act;

    assign act = {pll_reset, rst_core, rst_periph, ready, lock_lost, loss_count, retry_count};

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    function automatic logic [16:0] ov(input logic p, input logic c, input logic pe, input logic r,
                                       input logic l, input logic [7:0] lc, input logic [3:0] rc);
        return {p, c, pe, r, l, lc, rc};
    endfunction

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic logic [3:0] sat4(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    task automatic expect_at(input int c, input logic [16:0] v, input string nm);
        exp_t e;
        int   idx;
        bit   found;
        e.cyc  = c;
        e.vec  = v;
        e.name = nm;
        idx    = sb.size();
        found  = 0;
        for (int i = 0; i < sb.size(); i++) begin
            if (!found && sb[i].cyc > c) begin
                idx   = i;
                found = 1;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clkin);
    endtask

    // Expected relock timing for a lock raised at the negedge of cycle c
    task automatic relock(input int c, input logic l, input logic [7:0] lc, input logic [3:0] rc);
        expect_at(c + 9,  ov(0, 1, 1, 0, l, lc, rc), "core_held_before_release");
        expect_at(c + 10, ov(0, 0, 1, 0, l, lc, rc), "core_release");
        expect_at(c + 13, ov(0, 0, 1, 0, l, lc, rc), "periph_held_in_gap");
        expect_at(c + 14, ov(0, 0, 0, 1, l, lc, rc), "periph_release_ready");
        goto(c + 15);
    endtask

    // Drop lock while in RUN, expect a loss event, then relock into RUN
    task automatic loss_relock(input logic [7:0] new_loss, input logic [3:0] rc);
        int l;
        int c;
        l      = cyc;
        locked = 1'b0;
        expect_at(l + 3, ov(0, 1, 1, 0, 1, new_loss, rc), "loss_event");
        goto(l + 4);
        locked = 1'b1;
        c      = cyc;
        expect_at(c + 14, ov(0, 0, 0, 1, 1, new_loss, rc), "relock_ready");
        goto(c + 15);
    endtask

    // Monitor: invariant checks every cycle, scoreboard entries at their cycle
    always @(negedge clkin) begin
        n_chk = n_chk + 2;
        if (!rst_periph && rst_core) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_order cyc=%0d rst_core=%b rst_periph=%b required rst_periph=1", cyc, rst_core, rst_periph);
        end
        if (ready !== ~rst_periph) begin
            n_fail = n_fail + 1;
            $display("FAIL ready_vs_periph cyc=%0d ready=%b rst_periph=%b required ready=~rst_periph", cyc, ready, rst_periph);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_chk = n_chk + 1;
            if (mon_e.cyc != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s not sampled at cyc=%0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (act !== mon_e.vec) begin
                n_fail = n_fail + 1;
                $display("FAIL %s cyc=%0d got pll=%b core=%b periph=%b rdy=%b lost=%b loss=%0d retry=%0d required pll=%b core=%b periph=%b rdy=%b lost=%b loss=%0d retry=%0d",
                         mon_e.name, cyc, act[16], act[15], act[14], act[13], act[12], act[11:4], act[3:0],
                         mon_e.vec[16], mon_e.vec[15], mon_e.vec[14], mon_e.vec[13], mon_e.vec[12],
                         mon_e.vec[11:4], mon_e.vec[3:0]);
            end
        end
        if (end_req) begin
            while (sb.size() > 0) begin
                mon_e  = sb.pop_front();
                n_chk  = n_chk + 1;
                n_fail = n_fail + 1;
                $display("FAIL %s never sampled (cyc=%0d)", mon_e.name, mon_e.cyc);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // Directed stimulus with expected responses pushed to the scoreboard
    initial begin
        int r0;
        int c;
        int l;
        int w;
        int t;
        int x;

        rst          = 1'b1;
        locked       = 1'b0;
        clear_status = 1'b0;
        expect_at(1, ov(1, 1, 1, 0, 0, 8'd0, 4'd0), "reset_state");
        expect_at(2, ov(1, 1, 1, 0, 0, 8'd0, 4'd0), "reset_state_hold");

        // Power-up: pll_reset high 3 cycles, then lock-driven release
        goto(3);
        rst = 1'b0;
        r0  = cyc;
        expect_at(r0 + 2, ov(1, 1, 1, 0, 0, 8'd0, 4'd0), "pll_reset_hold");
        expect_at(r0 + 3, ov(0, 1, 1, 0, 0, 8'd0, 4'd0), "pll_reset_fall");
        goto(r0 + 3);
        locked = 1'b1;
        c      = cyc;
        relock(c, 0, 8'd0, 4'd0);

        // Lock loss in RUN followed by relock
        l      = cyc;
        locked = 1'b0;
        expect_at(l + 2, ov(0, 0, 0, 1, 0, 8'd0, 4'd0), "run_before_loss");
        expect_at(l + 3, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "loss_in_run");
        goto(l + 5);
        locked = 1'b1;
        c      = cyc;
        relock(c, 1, 8'd1, 4'd0);

        // clear_status coincident with a loss, then a lone clear
        l      = cyc;
        locked = 1'b0;
        expect_at(l + 2, ov(0, 0, 0, 1, 1, 8'd1, 4'd0), "run_before_clear_loss");
        expect_at(l + 3, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "clear_vs_loss");
        goto(l + 2);
        clear_status = 1'b1;
        goto(l + 3);
        clear_status = 1'b0;
        goto(l + 4);
        clear_status = 1'b1;
        expect_at(l + 5, ov(0, 1, 1, 0, 0, 8'd0, 4'd0), "lone_clear");
        goto(l + 5);
        clear_status = 1'b0;
        locked       = 1'b1;
        c            = cyc;
        relock(c, 0, 8'd0, 4'd0);

        // Unstable lock during STABLE, then repeated timeouts
        l      = cyc;
        locked = 1'b0;
        expect_at(l + 3, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "loss_before_unstable");
        goto(l + 4);
        locked = 1'b1;
        c      = cyc;
        goto(c + 5);
        locked = 1'b0;
        w      = c + 8;
        expect_at(c + 10, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "unstable_core_held");
        expect_at(c + 14, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "unstable_periph_held");
        expect_at(w + 31, ov(0, 1, 1, 0, 1, 8'd1, 4'd0), "before_first_timeout");
        for (int k = 1; k <= 16; k++) begin
            t = w + 32 + 35 * (k - 1);
            expect_at(t,     ov(1, 1, 1, 0, 1, 8'd1, sat4(k)), "timeout_pll_reset");
            expect_at(t + 2, ov(1, 1, 1, 0, 1, 8'd1, sat4(k)), "timeout_pll_hold");
            expect_at(t + 3, ov(0, 1, 1, 0, 1, 8'd1, sat4(k)), "timeout_pll_fall");
        end
        t = w + 32 + 35 * 15;
        goto(t + 5);

        // clear_status leaves retry_count alone; relock from WAIT_LOCK
        clear_status = 1'b1;
        locked       = 1'b1;
        c            = cyc;
        expect_at(c + 1, ov(0, 1, 1, 0, 0, 8'd0, 4'd15), "clear_keeps_retry");
        goto(c + 1);
        clear_status = 1'b0;
        relock(c, 0, 8'd0, 4'd15);

        // 256 loss events saturate loss_count at 255
        for (int i = 0; i < 256; i++) begin
            loss_relock(sat8(i + 1), 4'd15);
        end

        // Build loss_count=3 in RUN, then pulse rst asynchronously
        l            = cyc;
        clear_status = 1'b1;
        expect_at(l + 1, ov(0, 0, 0, 1, 0, 8'd0, 4'd15), "clear_in_run");
        goto(l + 1);
        clear_status = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            loss_relock(8'(i), 4'd15);
        end
        x = cyc;
        expect_at(x + 1,  ov(1, 1, 1, 0, 0, 8'd0, 4'd0), "mid_run_rst");
        expect_at(x + 2,  ov(1, 1, 1, 0, 0, 8'd0, 4'd0), "mid_run_rst_hold");
        expect_at(x + 3,  ov(0, 1, 1, 0, 0, 8'd0, 4'd0), "mid_run_rst_pll_fall");
        expect_at(x + 10, ov(0, 1, 1, 0, 0, 8'd0, 4'd0), "post_rst_core_held");
        expect_at(x + 11, ov(0, 0, 1, 0, 0, 8'd0, 4'd0), "post_rst_core_release");
        expect_at(x + 15, ov(0, 0, 0, 1, 0, 8'd0, 4'd0), "post_rst_ready");
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        goto(x + 18);
        end_req = 1'b1;
    end

endmodule
